feature_stream_feeder: RTL and testbench
========================================

Name: feature_stream_feeder

Overview:
- Transmit-side counterpart of the per-PE input feature shift register.
- Accepts one full row of ROW_LEN signed features in parallel through a valid/ready handshake. Clears the downstream shift register, then serialises the row one feature per clock, element 0 first.
- Optionally pads N-1 zero cycles so the row tail propagates through all N taps. Drives the downstream tap select.

Parameters:
N, 3, depth of the downstream feature shift register (taps)
I_WIDTH, 8, feature width in bits (signed)
ROW_LEN, 8, features per row; must be >= 1
SEL_WIDTH, $clog2(N), width of tap select
CNT_WIDTH, $clog2(ROW_LEN+N), width of the internal element/pad counter

Ports:
clk_i  in  1  clock, rising edge
rst_n_i  in  1  asynchronous active-low reset
row_data_i  in  ROW_LEN*I_WIDTH  packed row; element k = bits [k*I_WIDTH +: I_WIDTH]
row_valid_i  in  1  row_data_i valid
row_ready_o  out  1  feeder can accept a row
pad_en_i  in  1  sampled at acceptance; 1 = emit N-1 zero pad cycles after the row
tap_sel_i  in  SEL_WIDTH  sampled at acceptance; tap for the downstream select
out_feature_o  out  I_WIDTH  signed serial feature to the downstream shift register
out_valid_o  out  1  out_feature_o carries a row element
f_sel_o  out  SEL_WIDTH  downstream tap select
freg_rst_o  out  1  active-high clear pulse to the downstream shift register
row_done_o  out  1  one-cycle pulse when a row (and its padding) has completed

Behaviour:
- All outputs are registered. freg_rst_o must come straight from a flop, because downstream uses it as an asynchronous reset.
- Reset (rst_n_i low, immediate) sets:
  - state IDLE
  - row_ready_o=0, out_feature_o=0, out_valid_o=0, f_sel_o=0, freg_rst_o=0, row_done_o=0
  - holding register and counter cleared
- row_ready_o rises at the first clock edge after reset release.
- States: IDLE, CLEAR, STREAM, PAD, DONE.
- IDLE: row_ready_o=1. On an edge with row_valid_i&&row_ready_o:
  - latch row_data_i, pad_en_i, and tap_sel_i; clamp tap_sel_i to N-1 if it is >= N
  - f_sel_o takes the latched tap
  - row_ready_o drops
  - go to CLEAR
- CLEAR (exactly 1 cycle): freg_rst_o=1, out_valid_o=0, out_feature_o=0.
- STREAM (ROW_LEN cycles): cycle k drives element k with out_valid_o=1 and freg_rst_o=0.
- After element ROW_LEN-1: go to PAD if the latched pad_en is 1, else go to DONE.
- PAD (N-1 cycles; skipped when N=1): out_feature_o=0, out_valid_o=0.
- DONE (1 cycle): row_done_o=1, row_ready_o=1, outputs 0. Behaves as IDLE for acceptance, so a row may be accepted in this cycle (back-to-back operation).
- Timing, accept edge = edge 0, N=3, ROW_LEN=8:
  - freg_rst_o high in cycle 1
  - elements in cycles 2..9
  - pad in cycles 10..11
  - done/ready in cycle 12 (cycle 10 if pad disabled)
- Row period is ROW_LEN+2 cycles, plus N-1 when pad is enabled.
- No downstream backpressure: downstream shifts every clock, so out_feature_o is 0 whenever out_valid_o=0.
- row_valid_i while busy: ignored, no acceptance. row_data_i changes after acceptance have no effect on the current row.
- f_sel_o holds its value from acceptance until the next acceptance, including through IDLE.
- Reset mid-row: the row is dropped immediately and freg_rst_o deasserts. No row_done_o is issued for the dropped row.
- Counter never wraps: it saturates at its terminal count per state and reloads on each state entry.

Test Plan:
- Reset release, row_valid_i=1 with elements 1..8, pad_en=1, tap_sel=2 (N=3, ROW_LEN=8) -> row_ready_o=1 the first edge after release; freg_rst_o cycle 1; out_feature_o 1..8 cycles 2..9 with valid; zeros cycles 10..11; row_done_o and ready cycle 12; f_sel_o=2 throughout.
- Same row, pad_en=0 -> row_done_o in cycle 10; no pad cycles.
- Back-to-back: second row (elements -1..-8) held valid -> accepted in DONE cycle; next freg_rst_o exactly 1 cycle after done; signed values appear unchanged.
- tap_sel_i=3 with N=3 -> f_sel_o=2 (clamped).
- rst_n_i low during element 4 -> outputs 0 immediately, including freg_rst_o; no row_done_o; after release ready=1 and a fresh row streams correctly.
- row_valid_i pulsed while in STREAM, and row_data_i changed mid-row -> no acceptance; the original row is emitted intact.

Source files
------------

// File: rtl/feature_stream_feeder.sv
// Serialises one parallel row of signed features into a downstream feature shift register,
// pulsing the register clear first and optionally padding zeros so the row tail reaches every tap.
module feature_stream_feeder #(
    parameter int N         = 3,
    parameter int I_WIDTH   = 8,
    parameter int ROW_LEN   = 8,
    parameter int SEL_WIDTH = $clog2(N),
    parameter int CNT_WIDTH = $clog2(ROW_LEN + N)
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic [ROW_LEN*I_WIDTH-1:0]    row_data_i,
    input  logic                          row_valid_i,
    output logic                          row_ready_o,
    input  logic                          pad_en_i,
    input  logic [SEL_WIDTH-1:0]          tap_sel_i,
    output logic signed [I_WIDTH-1:0]     out_feature_o,
    output logic                          out_valid_o,
    output logic [SEL_WIDTH-1:0]          f_sel_o,
    output logic                          freg_rst_o,
    output logic                          row_done_o
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        STREAM = 3'd2,
        PAD    = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam bit HAS_PAD  = (N > 1);
    localparam int PAD_LAST = (N > 1) ? (N - 2) : 0;

    state_t                       state_r;
    logic [ROW_LEN*I_WIDTH-1:0]   row_r;
    logic                         pad_r;
    logic [CNT_WIDTH-1:0]         cnt_r;
    logic [SEL_WIDTH-1:0]         tap_clamp_s;
    logic                         accept_s;

    // Acceptance qualifier and out-of-range tap clamping
    always_comb begin
        tap_clamp_s = tap_sel_i;
        accept_s    = 1'b0;
        if ({1'b0, tap_sel_i} >= (SEL_WIDTH+1)'(N)) begin
            tap_clamp_s = SEL_WIDTH'(N - 1);
        end else begin
            tap_clamp_s = tap_sel_i;
        end
        if (row_valid_i && row_ready_o && ((state_r == IDLE) || (state_r == DONE))) begin
            accept_s = 1'b1;
        end else begin
            accept_s = 1'b0;
        end
    end

    // Sequencer: clear pulse, element stream (row_r shifts down one element per cycle), padding, done
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_r       <= IDLE;
            row_r         <= '0;
            pad_r         <= 1'b0;
            cnt_r         <= '0;
            row_ready_o   <= 1'b0;
            out_feature_o <= '0;
            out_valid_o   <= 1'b0;
            f_sel_o       <= '0;
            freg_rst_o    <= 1'b0;
            row_done_o    <= 1'b0;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    row_done_o    <= 1'b0;
                    out_feature_o <= '0;
                    out_valid_o   <= 1'b0;
                    cnt_r         <= '0;
                    if (accept_s) begin
                        row_r       <= row_data_i;
                        pad_r       <= pad_en_i;
                        f_sel_o     <= tap_clamp_s;
                        row_ready_o <= 1'b0;
                        freg_rst_o  <= 1'b1;
                        state_r     <= CLEAR;
                    end else begin
                        row_ready_o <= 1'b1;
                        freg_rst_o  <= 1'b0;
                        state_r     <= IDLE;
                    end
                end
                CLEAR: begin
                    freg_rst_o    <= 1'b0;
                    out_feature_o <= $signed(row_r[I_WIDTH-1:0]);
                    out_valid_o   <= 1'b1;
                    row_r         <= row_r >> I_WIDTH;
                    cnt_r         <= '0;
                    state_r       <= STREAM;
                end
                STREAM: begin
                    if (cnt_r == CNT_WIDTH'(ROW_LEN - 1)) begin
                        out_feature_o <= '0;
                        out_valid_o   <= 1'b0;
                        cnt_r         <= '0;
                        if (pad_r && HAS_PAD) begin
                            state_r <= PAD;
                        end else begin
                            row_done_o  <= 1'b1;
                            row_ready_o <= 1'b1;
                            state_r     <= DONE;
                        end
                    end else begin
                        out_feature_o <= $signed(row_r[I_WIDTH-1:0]);
                        out_valid_o   <= 1'b1;
                        row_r         <= row_r >> I_WIDTH;
                        cnt_r         <= cnt_r + CNT_WIDTH'(1);
                    end
                end
                PAD: begin
                    out_feature_o <= '0;
                    out_valid_o   <= 1'b0;
                    if (cnt_r == CNT_WIDTH'(PAD_LAST)) begin
                        cnt_r       <= '0;
                        row_done_o  <= 1'b1;
                        row_ready_o <= 1'b1;
                        state_r     <= DONE;
                    end else begin
                        cnt_r <= cnt_r + CNT_WIDTH'(1);
                    end
                end
                default: begin
                    state_r       <= IDLE;
                    cnt_r         <= '0;
                    row_ready_o   <= 1'b0;
                    out_feature_o <= '0;
                    out_valid_o   <= 1'b0;
                    freg_rst_o    <= 1'b0;
                    row_done_o    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_feature_stream_feeder.sv
// Directed bench for feature_stream_feeder (N=3, ROW_LEN=8): timing of clear/stream/pad/done,
// back-to-back rows, tap clamping, mid-row reset and busy-time input changes.
module tb_feature_stream_feeder;

    logic        clk;
    logic        rst_n;
    logic [63:0] row_data;
    logic        row_valid;
    logic        row_ready;
    logic        pad_en;
    logic [1:0]  tap_sel;
    logic [7:0]  out_feature;
    logic        out_valid;
    logic [1:0]  f_sel;
    logic        freg_rst;
    logic        row_done;

    int checks;
    int errors;
    logic [7:0] exp_elem [8];

    feature_stream_feeder #(.N(3), .I_WIDTH(8), .ROW_LEN(8)) dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .row_data_i    (row_data),
        .row_valid_i   (row_valid),
        .row_ready_o   (row_ready),
        .pad_en_i      (pad_en),
        .tap_sel_i     (tap_sel),
        .out_feature_o (out_feature),
        .out_valid_o   (out_valid),
        .f_sel_o       (f_sel),
        .freg_rst_o    (freg_rst),
        .row_done_o    (row_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Loads exp_elem with base+k (or -(k+1) when neg) and packs it into row_data
    task automatic load_row(input bit neg, input logic [7:0] base);
        for (int k = 0; k < 8; k++) begin
            if (neg) exp_elem[k] = 8'hFF - 8'(k);
            else     exp_elem[k] = base + 8'(k);
            row_data[k*8 +: 8] = exp_elem[k];
        end
    endtask

    // Called in cycle 1 (just after the accept edge); ends in the done cycle
    task automatic check_row(input bit pad, input logic [1:0] sel, input bit disturb);
        check_val("clr_freg",  32'(freg_rst), 32'd1);
        check_val("clr_valid", 32'(out_valid), 32'd0);
        check_val("clr_feat",  32'(out_feature), 32'd0);
        check_val("clr_ready", 32'(row_ready), 32'd0);
        check_val("clr_fsel",  32'(f_sel), 32'(sel));
        for (int k = 0; k < 8; k++) begin
            step();
            check_val("st_feat",  32'(out_feature), 32'(exp_elem[k]));
            check_val("st_valid", 32'(out_valid), 32'd1);
            check_val("st_freg",  32'(freg_rst), 32'd0);
            check_val("st_ready", 32'(row_ready), 32'd0);
            check_val("st_done",  32'(row_done), 32'd0);
            if (disturb && k == 3) begin
                row_valid = 1'b1;
                row_data  = 64'hA5A5_A5A5_A5A5_A5A5;
                pad_en    = 1'b1;
                tap_sel   = 2'd0;
            end
            if (disturb && k == 5) row_valid = 1'b0;
        end
        if (pad) begin
            for (int p = 0; p < 2; p++) begin
                step();
                check_val("pad_feat",  32'(out_feature), 32'd0);
                check_val("pad_valid", 32'(out_valid), 32'd0);
                check_val("pad_done",  32'(row_done), 32'd0);
            end
        end
        step();
        check_val("done_pulse", 32'(row_done), 32'd1);
        check_val("done_ready", 32'(row_ready), 32'd1);
        check_val("done_valid", 32'(out_valid), 32'd0);
        check_val("done_fsel",  32'(f_sel), 32'(sel));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        row_valid = 1'b1;
        pad_en = 1'b1;
        tap_sel = 2'd2;
        row_data = '0;
        load_row(1'b0, 8'd1);
        #3;
        check_val("rst_ready", 32'(row_ready), 32'd0);
        check_val("rst_feat",  32'(out_feature), 32'd0);
        check_val("rst_valid", 32'(out_valid), 32'd0);
        check_val("rst_fsel",  32'(f_sel), 32'd0);
        check_val("rst_freg",  32'(freg_rst), 32'd0);
        check_val("rst_done",  32'(row_done), 32'd0);
        step();
        step();
        rst_n = 1'b1;
        step();
        check_val("rel_ready", 32'(row_ready), 32'd1);
        check_val("rel_freg",  32'(freg_rst), 32'd0);

        // Row 1: elements 1..8, padded, tap 2
        step();
        row_valid = 1'b0;
        check_row(1'b1, 2'd2, 1'b0);

        step();
        check_val("idle_done",  32'(row_done), 32'd0);
        check_val("idle_ready", 32'(row_ready), 32'd1);

        // Row 2: same data, no pad, tap 3 clamps to 2, inputs disturbed mid-row
        row_valid = 1'b1;
        pad_en = 1'b0;
        tap_sel = 2'd3;
        load_row(1'b0, 8'd1);
        step();
        row_valid = 1'b0;
        check_row(1'b0, 2'd2, 1'b1);

        // Row 3 accepted in the DONE cycle: elements -1..-8, padded, tap 1
        row_valid = 1'b1;
        pad_en = 1'b1;
        tap_sel = 2'd1;
        load_row(1'b1, 8'd0);
        step();
        row_valid = 1'b0;
        check_row(1'b1, 2'd1, 1'b0);
        step();
        step();
        check_val("hold_fsel", 32'(f_sel), 32'd1);
        check_val("hold_done", 32'(row_done), 32'd0);

        // Row 4 interrupted by reset during element 4
        row_valid = 1'b1;
        pad_en = 1'b0;
        tap_sel = 2'd0;
        load_row(1'b0, 8'h10);
        step();
        row_valid = 1'b0;
        check_val("r4_freg", 32'(freg_rst), 32'd1);
        for (int k = 0; k < 4; k++) step();
        check_val("r4_elem4", 32'(out_feature), 32'h13);
        rst_n = 1'b0;
        #1;
        check_val("mid_feat",  32'(out_feature), 32'd0);
        check_val("mid_valid", 32'(out_valid), 32'd0);
        check_val("mid_freg",  32'(freg_rst), 32'd0);
        check_val("mid_ready", 32'(row_ready), 32'd0);
        for (int k = 0; k < 6; k++) begin
            step();
            check_val("mid_nodone", 32'(row_done), 32'd0);
        end
        rst_n = 1'b1;
        step();
        check_val("re_ready", 32'(row_ready), 32'd1);
        check_val("re_done",  32'(row_done), 32'd0);

        // Fresh row after reset
        row_valid = 1'b1;
        pad_en = 1'b1;
        tap_sel = 2'd2;
        load_row(1'b0, 8'd1);
        step();
        row_valid = 1'b0;
        check_row(1'b1, 2'd2, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
